run_sched: RTL and testbench
============================

Name: run_sched

Overview:
- Measurement-run sequencer in front of the statistics stage.
- Arms a run, waits a warm-up period, then holds the sent-start level for a programmed duration. It then pulses sent-end and waits a drain period before returning to idle.
- Programmed and polled over the 134-bit in-band configuration chain. Packets not addressed to it are forwarded unchanged to the next module on the chain.

Parameters:
- LMID, 8'd8, own module ID matched against control-packet destination field [103:96]
- BASE_ADDR, 32'h71000000, register base; registers are BASE_ADDR+0..+6
- CNT_W, 32, width of the warm-up, duration and drain counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cin_rs_data  in  134  config packet word; [133:132] 01=first, 10=second cycle
- cin_rs_data_wr  in  1  config word valid
- cout_rs_ready  out  1  combinational copy of cin_rs_ready
- cout_rs_data  out  134  config word to next module
- cout_rs_data_wr  out  1  config word valid out
- cin_rs_ready  in  1  downstream ready
- in_rs_pkt_wr  in  1  one pulse per packet emitted by the generator (used by the optional feature)
- rs2scm_sent_start  out  1  level, high while in the RUN state
- rs2scm_sent_end  out  1  one-cycle pulse on RUN->DRAIN
- rs2scm_stat_clr  out  1  one-cycle pulse when a run is armed
- rs_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, active-high, one clock and one reset as decided.
  - All outputs are 0; state is IDLE.
  - WARMUP, DURATION and DRAIN registers are 0; RUN_COUNT is 0.
  - Reset mid-run drops sent_start in the next cycle with no sent_end pulse.
- Registers (word offset: meaning):
  - +0 CTRL: write bit0=start, bit1=abort; both self-clearing.
  - +1 WARMUP, +2 DURATION, +3 DRAIN: read/write, CNT_W bits.
  - +4 STATUS: read only, {29'b0, state[2:0]}.
  - +5 RUN_COUNT: read only; completed runs, wraps at 2^32.
  - +6 PKT_LIMIT: see Optional Feature.
- Control-packet decode, first cycle with [133:132]=01 and [103:96]=LMID:
  - Write, [126:124]=010: update the register at [95:64] with data [31:0].
    - Both words of the packet are consumed; cout_rs_data_wr stays 0 for both.
  - Read, [126:124]=001: next cycle emit a response word.
    - Response word is {[133:128], 4'b1011, [123:112], [103:96], [111:104], [95:32], rdata}.
    - The second word is forwarded unchanged in the following cycle.
    - An unmapped address returns 32'hFFFFFFFF.
- Any other packet, or a packet for another LMID: forwarded with one-cycle latency, word-for-word.
- No word is dropped; the module does not apply backpressure.
- States: IDLE(0), WARMUP(1), RUN(2), DRAIN(3), DONE(4).
- IDLE, on start write:
  - Pulse stat_clr, load cnt=WARMUP, go to WARMUP.
  - A start write in any other state is ignored.
- WARMUP:
  - Decrement cnt each cycle; at cnt==0 load cnt=DURATION and go to RUN.
  - WARMUP=0 gives exactly 1 cycle in WARMUP.
- RUN:
  - sent_start=1; decrement cnt; at cnt==0 pulse sent_end, load cnt=DRAIN, go to DRAIN.
  - DURATION=0 gives 1 RUN cycle.
  - DURATION changes during a run are not seen until the next run.
- DRAIN: decrement cnt; at cnt==0 go to DONE.
- DONE: RUN_COUNT+=1, go to IDLE (1 cycle).
- Abort write, in any state other than IDLE:
  - Go to IDLE next cycle; sent_start drops.
  - If aborted from RUN, sent_end pulses once; RUN_COUNT is not incremented.
- Same-cycle start and abort: abort wins.
- Register writes while busy take effect immediately in the register, but not in the loaded cnt.

Optional Feature:
- Macro: RUN_SCHED_PKT_LIMIT_EN.
- When defined:
  - PKT_LIMIT register (+6) exists.
  - pkt_cnt clears on arm and increments on in_rs_pkt_wr only in RUN.
  - RUN also exits (sent_end pulse, then DRAIN) in the cycle pkt_cnt reaches a nonzero PKT_LIMIT, whichever of limit or duration comes first.
  - PKT_LIMIT=0 disables the limit.
- When undefined: +6 reads 32'hFFFFFFFF, writes are ignored, and in_rs_pkt_wr is unused.

Test Plan:
- Write WARMUP=3, DURATION=10, DRAIN=2, then CTRL=1.
  - stat_clr pulses 1 cycle, then 4 WARMUP cycles, then sent_start high exactly 11 cycles.
  - sent_end pulses once as sent_start falls; busy clears 4 cycles later; RUN_COUNT reads 1.
- Read +4 during RUN -> response data 32'h00000002 with opcode nibble 1011 and src/dst swapped; the second word follows next cycle.
- Abort write 5 cycles into RUN -> sent_start low next cycle, one sent_end pulse, state 0, RUN_COUNT unchanged.
- Packet with [103:96]=8'd7 -> both words appear on cout 1 cycle later, bit-identical.
- Read of +7 -> 32'hFFFFFFFF. Start write while busy -> no stat_clr, no state change.
- With RUN_SCHED_PKT_LIMIT_EN: PKT_LIMIT=4, DURATION=100, pkt pulse every 2 cycles -> RUN ends on the 4th pulse. Assert rst mid-RUN -> all outputs 0 next cycle, no sent_end.

Source files
------------

// File: rtl/run_sched.sv
// run_sched: measurement-run sequencer (IDLE -> WARMUP -> RUN -> DRAIN -> DONE)
// controlled over the 134-bit in-band configuration chain.
// Optional build macro RUN_SCHED_PKT_LIMIT_EN adds the PKT_LIMIT register (+6)
// that can end RUN early after a programmed number of generator packets.
// Chain handshake: a word is valid in any cycle its *_wr strobe is high; there
// is no backpressure, so every valid word is consumed in the cycle it arrives
// and cout_rs_ready is only a pass-through of the downstream ready.
module run_sched #(
  parameter logic [7:0]  LMID      = 8'd8,
  parameter logic [31:0] BASE_ADDR = 32'h71000000,
  parameter int          CNT_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] cin_rs_data,
  input  logic         cin_rs_data_wr,
  output logic         cout_rs_ready,
  output logic [133:0] cout_rs_data,
  output logic         cout_rs_data_wr,
  input  logic         cin_rs_ready,
  input  logic         in_rs_pkt_wr,
  output logic         rs2scm_sent_start,
  output logic         rs2scm_sent_end,
  output logic         rs2scm_stat_clr,
  output logic         rs_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_warmup;
  logic [CNT_W-1:0] r_duration;
  logic [CNT_W-1:0] r_drain;
  logic [31:0]      r_run_count;
  logic             r_sent_end;
  logic             r_stat_clr;
  logic [133:0]     r_cout_data;
  logic             r_cout_wr;
  logic             r_drop;

  // Control-packet decode on the first word of a packet addressed to us
  logic        w_first, w_mine, w_is_wr, w_is_rd;
  logic [31:0] w_off;
  logic        w_start, w_abort;
  logic [31:0] w_rdata;
  logic        w_pkt_hit;

  assign w_first = cin_rs_data_wr && (cin_rs_data[133:132] == 2'b01);
  assign w_mine  = w_first && (cin_rs_data[103:96] == LMID);
  assign w_is_wr = w_mine && (cin_rs_data[126:124] == 3'b010);
  assign w_is_rd = w_mine && (cin_rs_data[126:124] == 3'b001);
  assign w_off   = cin_rs_data[95:64] - BASE_ADDR;
  assign w_start = w_is_wr && (w_off == 32'd0) && cin_rs_data[0];
  assign w_abort = w_is_wr && (w_off == 32'd0) && cin_rs_data[1];

  assign cout_rs_ready   = cin_rs_ready;
  assign cout_rs_data    = r_cout_data;
  assign cout_rs_data_wr = r_cout_wr;

`ifdef RUN_SCHED_PKT_LIMIT_EN
  logic [31:0] r_pkt_limit;
  logic [31:0] r_pkt_cnt;

  // Limit is reached in the cycle the counted packet makes pkt_cnt equal PKT_LIMIT
  assign w_pkt_hit = (r_state == S_RUN) && in_rs_pkt_wr && (r_pkt_limit != 32'd0) &&
                     ((r_pkt_cnt + 32'd1) == r_pkt_limit);

  // Packet counter: cleared when a run is armed, counts generator packets only in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt <= 32'd0;
    end else if (r_state == S_IDLE && w_state_nxt == S_WARMUP) begin
      r_pkt_cnt <= 32'd0;
    end else if (r_state == S_RUN && in_rs_pkt_wr) begin
      r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end
`else
  // Without the limit the generator strobe has no effect on the sequence
  assign w_pkt_hit = in_rs_pkt_wr & 1'b0;
`endif

  // Register read mux; unmapped offsets return all ones
  always_comb begin
    w_rdata = 32'hFFFFFFFF;
    case (w_off)
      32'd0: w_rdata = 32'd0;
      32'd1: w_rdata = 32'(r_warmup);
      32'd2: w_rdata = 32'(r_duration);
      32'd3: w_rdata = 32'(r_drain);
      32'd4: w_rdata = {29'd0, r_state};
      32'd5: w_rdata = r_run_count;
`ifdef RUN_SCHED_PKT_LIMIT_EN
      32'd6: w_rdata = r_pkt_limit;
`endif
      default: w_rdata = 32'hFFFFFFFF;
    endcase
  end

  // Configuration registers and completed-run counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_warmup    <= '0;
      r_duration  <= '0;
      r_drain     <= '0;
      r_run_count <= 32'd0;
`ifdef RUN_SCHED_PKT_LIMIT_EN
      r_pkt_limit <= 32'd0;
`endif
    end else begin
      if (w_is_wr) begin
        case (w_off)
          32'd1: r_warmup   <= CNT_W'(cin_rs_data[31:0]);
          32'd2: r_duration <= CNT_W'(cin_rs_data[31:0]);
          32'd3: r_drain    <= CNT_W'(cin_rs_data[31:0]);
`ifdef RUN_SCHED_PKT_LIMIT_EN
          32'd6: r_pkt_limit <= cin_rs_data[31:0];
`endif
          default: ;
        endcase
      end
      if (r_state == S_DONE) begin
        r_run_count <= r_run_count + 32'd1;
      end
    end
  end

  // Chain path: consume writes (both words), answer reads, forward everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cout_data <= '0;
      r_cout_wr   <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_cout_wr <= 1'b0;
      if (cin_rs_data_wr) begin
        if (w_is_wr) begin
          r_drop <= 1'b1;
        end else if (w_is_rd) begin
          r_cout_wr   <= 1'b1;
          r_cout_data <= {cin_rs_data[133:128], 4'b1011, cin_rs_data[123:112],
                          cin_rs_data[103:96], cin_rs_data[111:104],
                          cin_rs_data[95:32], w_rdata};
        end else if (r_drop) begin
          r_drop <= 1'b0;
        end else begin
          r_cout_wr   <= 1'b1;
          r_cout_data <= cin_rs_data;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; abort beats everything except in IDLE where it is a no-op
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start && !w_abort) w_state_nxt = S_WARMUP;
      S_WARMUP: if (r_cnt == '0) w_state_nxt = S_RUN;
      S_RUN:    if (r_cnt == '0 || w_pkt_hit) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_abort && r_state != S_IDLE) w_state_nxt = S_IDLE;
  end

  // Phase counter: loaded from the registers on each phase entry, so later writes wait for the next run
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (w_state_nxt == S_WARMUP) r_cnt <= r_warmup;
        S_WARMUP: r_cnt <= (r_cnt == '0) ? r_duration : r_cnt - CNT_W'(1);
        S_RUN:    r_cnt <= (r_cnt == '0 || w_pkt_hit) ? r_drain : r_cnt - CNT_W'(1);
        S_DRAIN:  if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        default:  ;
      endcase
    end
  end

  // One-cycle pulses: stat_clr on arming, sent_end on any exit from RUN other than reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_clr <= 1'b0;
      r_sent_end <= 1'b0;
    end else begin
      r_stat_clr <= (r_state == S_IDLE) && (w_state_nxt == S_WARMUP);
      r_sent_end <= (r_state == S_RUN) && (w_state_nxt != S_RUN);
    end
  end

  // FSM outputs
  always_comb begin
    rs2scm_sent_start = (r_state == S_RUN);
    rs_busy           = (r_state != S_IDLE);
    rs2scm_sent_end   = r_sent_end;
    rs2scm_stat_clr   = r_stat_clr;
  end

endmodule

// File: tb/tb_run_sched.sv
// Testbench for run_sched: register access table, run timing sequences,
// abort / busy-start / reset corner cases, and a scoreboard on the chain output.
// Honours RUN_SCHED_PKT_LIMIT_EN to select the packet-limit scenario.
module tb_run_sched;

  localparam logic [7:0]  LMID = 8'd8;
  localparam logic [31:0] BASE = 32'h71000000;

  logic         clk = 1'b0;
  logic         rst;
  logic [133:0] cin_rs_data;
  logic         cin_rs_data_wr;
  logic         cout_rs_ready;
  logic [133:0] cout_rs_data;
  logic         cout_rs_data_wr;
  logic         cin_rs_ready;
  logic         in_rs_pkt_wr;
  logic         rs2scm_sent_start;
  logic         rs2scm_sent_end;
  logic         rs2scm_stat_clr;
  logic         rs_busy;

  run_sched dut (
    .clk(clk), .rst(rst),
    .cin_rs_data(cin_rs_data), .cin_rs_data_wr(cin_rs_data_wr),
    .cout_rs_ready(cout_rs_ready), .cout_rs_data(cout_rs_data),
    .cout_rs_data_wr(cout_rs_data_wr), .cin_rs_ready(cin_rs_ready),
    .in_rs_pkt_wr(in_rs_pkt_wr),
    .rs2scm_sent_start(rs2scm_sent_start), .rs2scm_sent_end(rs2scm_sent_end),
    .rs2scm_stat_clr(rs2scm_stat_clr), .rs_busy(rs_busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [133:0] exp_q[$];
  logic [133:0] sb_exp;

  task automatic chk(input string name, input logic [133:0] got, input logic [133:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // scoreboard on the chain output
  always @(negedge clk) begin
    if (cout_rs_data_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL cout_unexpected: got %h expected no word", cout_rs_data);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("cout_word", cout_rs_data, sb_exp);
      end
    end
  end

  // event monitor on the run outputs
  int cyc = 0;
  int clr_cnt, clr_cyc, start_cnt, start_rise, start_fall, end_cnt, end_cyc, busy_fall;
  logic prev_start = 1'b0, prev_busy = 1'b0;

  task automatic clr_ev();
    clr_cnt = 0; clr_cyc = -1; start_cnt = 0; start_rise = -1; start_fall = -1;
    end_cnt = 0; end_cyc = -1; busy_fall = -1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rs2scm_stat_clr) begin clr_cnt++; clr_cyc = cyc; end
    if (rs2scm_sent_start && !prev_start) start_rise = cyc;
    if (!rs2scm_sent_start && prev_start) start_fall = cyc;
    if (rs2scm_sent_start) start_cnt++;
    if (rs2scm_sent_end) begin end_cnt++; end_cyc = cyc; end
    if (!rs_busy && prev_busy) busy_fall = cyc;
    prev_start = rs2scm_sent_start;
    prev_busy  = rs_busy;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [133:0] mk_w1(input logic [2:0] op, input logic [7:0] dst,
                                         input logic [31:0] addr, input logic [31:0] data);
    logic [133:0] w;
    w = '0;
    w[133:132] = 2'b01;
    w[131:128] = 4'($urandom_range(0, 15));
    w[127]     = 1'($urandom_range(0, 1));
    w[126:124] = op;
    w[123:112] = 12'($urandom_range(0, 4095));
    w[111:104] = 8'h3C;
    w[103:96]  = dst;
    w[95:64]   = addr;
    w[63:32]   = $urandom;
    w[31:0]    = data;
    return w;
  endfunction

  function automatic logic [133:0] mk_w2();
    logic [133:0] w;
    w[133:132] = 2'b10;
    w[131:128] = 4'($urandom_range(0, 15));
    w[127:96]  = $urandom;
    w[95:64]   = $urandom;
    w[63:32]   = $urandom;
    w[31:0]    = $urandom;
    return w;
  endfunction

  task automatic send_pkt(input logic [133:0] w1, input logic [133:0] w2);
    cin_rs_data = w1; cin_rs_data_wr = 1'b1; tick();
    cin_rs_data = w2; tick();
    cin_rs_data = '0; cin_rs_data_wr = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    send_pkt(mk_w1(3'b010, LMID, BASE + 32'(off), data), mk_w2());
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] exp);
    logic [133:0] w1, w2;
    w1 = mk_w1(3'b001, LMID, BASE + 32'(off), $urandom);
    w2 = mk_w2();
    exp_q.push_back({w1[133:128], 4'b1011, w1[123:112], w1[103:96], w1[111:104], w1[95:32], exp});
    exp_q.push_back(w2);
    send_pkt(w1, w2);
  endtask

  task automatic fwd(input logic [2:0] op, input logic [7:0] dst);
    logic [133:0] w1, w2;
    w1 = mk_w1(op, dst, BASE + 32'd1, 32'd99);
    w2 = mk_w2();
    exp_q.push_back(w1);
    exp_q.push_back(w2);
    send_pkt(w1, w2);
  endtask

  // sel 0: sent_start, 1: busy
  task automatic wait_for(input int sel, input logic val, input string name);
    int n;
    n = 0;
    while (((sel == 0) ? rs2scm_sent_start : rs_busy) !== val && n < 300) begin
      tick(); n++;
    end
    chk(name, (sel == 0) ? rs2scm_sent_start : rs_busy, val);
  endtask

  typedef struct {
    bit          is_rd;
    logic [2:0]  off;
    logic [31:0] val;
  } vec_t;

  vec_t vecs[12];
  int   snap;

  initial begin
`ifdef RUN_SCHED_PKT_LIMIT_EN
    logic [31:0] exp6 = 32'd0;
`else
    logic [31:0] exp6 = 32'hFFFFFFFF;
`endif
    vecs[0]  = '{1'b1, 3'd1, 32'd0};
    vecs[1]  = '{1'b1, 3'd5, 32'd0};
    vecs[2]  = '{1'b1, 3'd4, 32'd0};
    vecs[3]  = '{1'b0, 3'd1, 32'd3};
    vecs[4]  = '{1'b0, 3'd2, 32'd10};
    vecs[5]  = '{1'b0, 3'd3, 32'd2};
    vecs[6]  = '{1'b1, 3'd1, 32'd3};
    vecs[7]  = '{1'b1, 3'd2, 32'd10};
    vecs[8]  = '{1'b1, 3'd3, 32'd2};
    vecs[9]  = '{1'b1, 3'd0, 32'd0};
    vecs[10] = '{1'b1, 3'd7, 32'hFFFFFFFF};
    vecs[11] = '{1'b1, 3'd6, exp6};

    rst = 1'b1; cin_rs_data = '0; cin_rs_data_wr = 1'b0; cin_rs_ready = 1'b1; in_rs_pkt_wr = 1'b0;
    clr_ev();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sent_start", rs2scm_sent_start, 0);
    chk("rst_sent_end", rs2scm_sent_end, 0);
    chk("rst_stat_clr", rs2scm_stat_clr, 0);
    chk("rst_busy", rs_busy, 0);
    chk("rst_cout_wr", cout_rs_data_wr, 0);
    chk("ready_copy", cout_rs_ready, 1);
    rst = 1'b0;
    tick();

    // register access table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_rd) rd(vecs[i].off, vecs[i].val);
      else               wr(vecs[i].off, vecs[i].val);
    end

    // full run: WARMUP=3, DURATION=10, DRAIN=2
    clr_ev();
    wr(3'd0, 32'd1);
    wait_for(1, 1'b0, "run1_done");
    tick();
    chk("run1_clr_cnt", clr_cnt, 1);
    chk("run1_warmup_len", start_rise - clr_cyc, 4);
    chk("run1_start_len", start_cnt, 11);
    chk("run1_end_cnt", end_cnt, 1);
    chk("run1_end_at_fall", end_cyc, start_fall);
    chk("run1_busy_tail", busy_fall - end_cyc, 4);
    rd(3'd5, 32'd1);

    // STATUS read during RUN
    wr(3'd0, 32'd1);
    wait_for(0, 1'b1, "run2_start");
    rd(3'd4, 32'd2);
    wait_for(1, 1'b0, "run2_done");
    rd(3'd5, 32'd2);

    // abort 5 cycles into RUN
    wr(3'd0, 32'd1);
    wait_for(0, 1'b1, "abort_start");
    repeat (5) tick();
    clr_ev();
    snap = cyc;
    wr(3'd0, 32'd2);
    repeat (3) tick();
    chk("abort_fall", start_fall, snap + 2);
    chk("abort_end_cnt", end_cnt, 1);
    chk("abort_end_cyc", end_cyc, snap + 2);
    chk("abort_busy", rs_busy, 0);
    rd(3'd4, 32'd0);
    rd(3'd5, 32'd2);

    // start while busy is ignored
    wr(3'd0, 32'd1);
    wait_for(0, 1'b1, "busy_start");
    clr_ev();
    wr(3'd0, 32'd1);
    repeat (2) tick();
    chk("busy_start_no_clr", clr_cnt, 0);
    rd(3'd4, 32'd2);
    wait_for(1, 1'b0, "busy_run_done");
    rd(3'd5, 32'd3);

    // start and abort together in IDLE: abort wins
    clr_ev();
    wr(3'd0, 32'd3);
    repeat (3) tick();
    chk("start_abort_clr", clr_cnt, 0);
    chk("start_abort_busy", rs_busy, 0);

    // all-zero phase lengths
    wr(3'd1, 32'd0); wr(3'd2, 32'd0); wr(3'd3, 32'd0);
    clr_ev();
    wr(3'd0, 32'd1);
    wait_for(1, 1'b0, "zero_done");
    tick();
    chk("zero_start_len", start_cnt, 1);
    chk("zero_warmup_len", start_rise - clr_cyc, 1);
    chk("zero_busy_tail", busy_fall - end_cyc, 2);
    rd(3'd5, 32'd4);

    // generator packets during RUN
`ifdef RUN_SCHED_PKT_LIMIT_EN
    wr(3'd6, 32'd4); wr(3'd2, 32'd100);
    rd(3'd6, 32'd4);
`else
    wr(3'd6, 32'd4); wr(3'd2, 32'd20);
    rd(3'd6, 32'hFFFFFFFF);
`endif
    clr_ev();
    wr(3'd0, 32'd1);
    wait_for(0, 1'b1, "pkt_start");
    snap = 0;
    for (int i = 0; i < 4; i++) begin
      in_rs_pkt_wr = 1'b1;
      if (i == 3) snap = cyc;
      tick();
      in_rs_pkt_wr = 1'b0;
      tick();
    end
    wait_for(1, 1'b0, "pkt_done");
    tick();
    chk("pkt_end_cnt", end_cnt, 1);
`ifdef RUN_SCHED_PKT_LIMIT_EN
    chk("pkt_limit_fall", start_fall, snap + 2);
    chk("pkt_limit_len", start_cnt, 7);
    wr(3'd6, 32'd0);
`else
    chk("pkt_ignored_len", start_cnt, 21);
`endif
    rd(3'd5, 32'd5);

    // foreign and non-register packets forwarded unchanged
    fwd(3'b010, 8'd7);
    fwd(3'b001, 8'd7);
    fwd(3'b011, LMID);
    rd(3'd7, 32'hFFFFFFFF);

    // reset mid-RUN
    wr(3'd2, 32'd10);
    wait_for(1, 1'b0, "pre_rst_idle");
    wr(3'd0, 32'd1);
    wait_for(0, 1'b1, "rst_run_start");
    repeat (2) tick();
    clr_ev();
    rst = 1'b1;
    tick();
    chk("midrst_sent_start", rs2scm_sent_start, 0);
    chk("midrst_sent_end", rs2scm_sent_end, 0);
    chk("midrst_stat_clr", rs2scm_stat_clr, 0);
    chk("midrst_busy", rs_busy, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("midrst_no_end", end_cnt, 0);
    rd(3'd1, 32'd0);
    rd(3'd2, 32'd0);
    rd(3'd5, 32'd0);

    repeat (4) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
